alu_cmd_sequencer: RTL

//   Initiator side of the 4-bit ALU interface: accepts commands on a valid/ready port, drives

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the ALU command sequencer.
//   alu_op_e    : ALU opcode encoding. Values above ALU_OP_LAST are illegal.
//   seq_state_e : sequencer FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'b0000,
        SUB   = 4'b0001,
        NEG   = 4'b0010,
        INC   = 4'b0011,
        DEC   = 4'b0100,
        ROL   = 4'b0101,
        OR    = 4'b0110,
        AND   = 4'b0111,
        XOR   = 4'b1000,
        MAX   = 4'b1001,
        PASSA = 4'b1010,
        PASSB = 4'b1011
    } alu_op_e;

    localparam logic [3:0] ALU_OP_LAST = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational ALU. A command is accepted on a valid/ready
// port, its operands/opcode are registered onto alu_*, the ALU settles for one
// EXEC cycle, and the result/flags are captured into a held response.
// Also keeps an accumulator for chained ops, a sticky overflow flag and a
// saturating count of executed commands.
//   clk, rst                      : clock, async active-high reset
//   cmd_valid/cmd_ready, cmd_*    : command port (cmd_use_acc selects acc as A)
//   alu_a/alu_b/alu_ctrl          : registered ALU inputs
//   alu_result/alu_carry/alu_ovf  : combinational ALU outputs
//   rsp_valid/rsp_ready, rsp_*    : response port
//   acc, sticky_ovf, clr_sticky   : accumulator and sticky overflow control
//   op_count                      : executed commands, saturating
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CTRL_W-1:0] cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_ovf,
    output logic              rsp_illegal,
    output logic [DATA_W-1:0] acc,
    output logic              sticky_ovf,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  op_count
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              illegal_q, illegal_d;   // illegal flag of the in-flight command
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic capture;

    // In RESP a new command may be taken only in the cycle the response leaves.
    assign cmd_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = (state_q == S_EXEC);

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        illegal_d     = illegal_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_illegal_d = rsp_illegal_q;
        acc_d         = acc_q;
        sticky_d      = sticky_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: if (accept) state_d = S_EXEC;
            S_EXEC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
            end
            S_RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = cmd_valid ? S_EXEC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            alu_a_d    = cmd_use_acc ? acc_q : cmd_a;
            alu_b_d    = cmd_b;
            alu_ctrl_d = cmd_op;
            illegal_d  = (cmd_op > CTRL_W'(ALU_OP_LAST));
        end

        if (capture) begin
            rsp_result_d  = alu_result;
            rsp_carry_d   = alu_carry;
            rsp_ovf_d     = alu_ovf;
            rsp_illegal_d = illegal_q;
            if (!illegal_q) acc_d = alu_result;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end

        // A captured overflow outranks a same-cycle clear.
        if (capture && alu_ovf) sticky_d = 1'b1;
        else if (clr_sticky)    sticky_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= '0;
            illegal_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
            acc_q         <= '0;
            sticky_q      <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            illegal_q     <= illegal_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_illegal_q <= rsp_illegal_d;
            acc_q         <= acc_d;
            sticky_q      <= sticky_d;
            cnt_q         <= cnt_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_illegal = rsp_illegal_q;
    assign acc         = acc_q;
    assign sticky_ovf  = sticky_q;
    assign op_count    = cnt_q;

endmodule
